psg_multi: RTL and testbench

Parametrised programmable sound generator: NUM_CH time-multiplexed voices, each with its own phase accumulator, waveform, pulse width, volume and L/R enable. All voices are summed into saturated stereo samples. Sits between the CPU register interface (attribute writes) and the audio FIFO/DAC path, driven by the sample-rate strobe `next_sample`. Over the single-bank PSG it adds configurable channel count, saturating accumulation, `sample_valid`/`overrun` handshake outputs and optional volume slewing.

---
 rtl/psg_multi.sv | 258 +++++++++++++++++++++++++
 tb/tb_psg_multi.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_multi.sv
// rtl/psg_multi.sv - time-multiplexed multi-voice sound generator with saturated stereo mix
//
// Optional feature macro: PSG_VOL_SLEW_EN
//   When defined, each voice keeps an effective volume that steps by one toward
//   the programmed volume once per sample. When undefined, the programmed volume
//   is used directly.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   attr_addr     attribute byte address {channel, byte}
//   attr_wrdata   attribute write data
//   attr_write    attribute write strobe, one byte per cycle, accepted in any state
//   next_sample   one-cycle strobe that starts a new sample computation
//   left_audio    saturated signed left sample, held between updates
//   right_audio   saturated signed right sample, held between updates
//   sample_valid  one-cycle pulse when new samples are presented
//   overrun       pulses in the same cycle as a next_sample that arrives while busy

module psg_multi #(
  parameter int NUM_CH = 16,
  parameter int OUT_W  = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH_W+1:0]  attr_addr,
  input  logic [7:0]       attr_wrdata,
  input  logic             attr_write,
  input  logic             next_sample,
  output logic [OUT_W-1:0] left_audio,
  output logic [OUT_W-1:0] right_audio,
  output logic             sample_valid,
  output logic             overrun
);

  // Accumulator wide enough for NUM_CH products of 12 bits plus headroom.
  localparam int ACC_W = OUT_W + CH_W + 1;

  localparam logic [5:0] GAIN [64] = '{
    6'd0,  6'd1,  6'd1,  6'd1,  6'd2,  6'd2,  6'd2,  6'd2,
    6'd2,  6'd2,  6'd2,  6'd3,  6'd3,  6'd3,  6'd3,  6'd3,
    6'd4,  6'd4,  6'd4,  6'd4,  6'd5,  6'd5,  6'd5,  6'd6,
    6'd6,  6'd7,  6'd7,  6'd7,  6'd8,  6'd8,  6'd9,  6'd9,
    6'd10, 6'd11, 6'd11, 6'd12, 6'd13, 6'd14, 6'd14, 6'd15,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd21, 6'd22, 6'd23, 6'd25,
    6'd26, 6'd28, 6'd29, 6'd31, 6'd33, 6'd35, 6'd37, 6'd39,
    6'd42, 6'd44, 6'd47, 6'd50, 6'd52, 6'd56, 6'd59, 6'd63
  };

  typedef enum logic [1:0] {IDLE, FETCH, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [CH_W-1:0] ch, ch_nx;
  logic [2:0]      bsel, bsel_nx;
  logic            clr_acc, shift_en, do_calc, load_out;

  // Attribute RAM (write port from the CPU side, registered read port for the FSM)
  logic [7:0]      attr_mem [NUM_CH*4];
  logic [CH_W+1:0] rd_addr;
  logic [7:0]      rd_data;
  logic [31:0]     attr_word;

  // Working RAM, never reset
  logic [16:0]     phase_mem [NUM_CH];
  logic [5:0]      noise_mem [NUM_CH];

  logic [15:0]     lfsr;
  logic [5:0]      noise_sr;

  logic signed [ACC_W-1:0] acc_l, acc_r, prod_ext;

  logic [15:0]     freq;
  logic [5:0]      vol, pw, wave_val, sig, vol_idx, noise_cur, noise_new;
  logic [1:0]      wave;
  logic            left_en, right_en;
  logic [16:0]     phase_cur, phase_new;
  logic signed [11:0] prod;

  assign freq     = attr_word[15:0];
  assign vol      = attr_word[21:16];
  assign left_en  = attr_word[22];
  assign right_en = attr_word[23];
  assign pw       = attr_word[29:24];
  assign wave     = attr_word[31:30];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ch    <= '0;
      bsel  <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
      bsel  <= bsel_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    bsel_nx  = bsel;
    clr_acc  = 1'b0;
    shift_en = 1'b0;
    do_calc  = 1'b0;
    load_out = 1'b0;
    overrun  = next_sample && (state != IDLE);
    case (state)
      IDLE: begin
        if (next_sample) begin
          state_nx = FETCH;
          ch_nx    = '0;
          bsel_nx  = '0;
          clr_acc  = 1'b1;
        end
      end
      FETCH: begin
        // Read data lags the issued address by one cycle, so bytes 0..3
        // are captured on the cycles where bsel is 1..4.
        shift_en = (bsel != 3'd0);
        if (bsel == 3'd4) begin
          state_nx = CALC;
        end else begin
          bsel_nx = bsel + 3'd1;
        end
      end
      CALC: begin
        do_calc = 1'b1;
        bsel_nx = '0;
        if (ch == CH_W'(NUM_CH - 1)) begin
          state_nx = DONE;
        end else begin
          ch_nx    = ch + CH_W'(1);
          state_nx = FETCH;
        end
      end
      DONE: begin
        load_out = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- Attribute RAM ----------------
  assign rd_addr = {ch, bsel[1:0]};

  always_ff @(posedge clk) begin
    if (attr_write) begin
      attr_mem[attr_addr] <= attr_wrdata;
    end
    rd_data <= attr_mem[rd_addr];
  end

  // ---------------- Voice computation ----------------
  assign phase_cur = phase_mem[ch];
  assign phase_new = phase_cur + {1'b0, freq};
  assign noise_cur = noise_mem[ch];
  // Latch fresh noise only when the phase MSB falls across this update.
  assign noise_new = (phase_cur[16] && !phase_new[16]) ? noise_sr : noise_cur;

  always_comb begin
    wave_val = 6'd0;
    case (wave)
      2'b00:   wave_val = (phase_cur[16:10] > {1'b0, pw}) ? 6'd0 : 6'd63;
      2'b01:   wave_val = phase_cur[16:11];
      2'b10:   wave_val = phase_cur[16] ? ~phase_cur[15:10] : phase_cur[15:10];
      default: wave_val = noise_cur;
    endcase
  end

`ifdef PSG_VOL_SLEW_EN
  logic [5:0] eff_mem [NUM_CH];
  logic [5:0] eff_cur, eff_nx;

  assign eff_cur = eff_mem[ch];
  // Mixing uses the pre-step value; the stored value moves one step per sample.
  assign vol_idx = eff_cur;

  always_comb begin
    eff_nx = eff_cur;
    if (eff_cur < vol) begin
      eff_nx = eff_cur + 6'd1;
    end else if (eff_cur > vol) begin
      eff_nx = eff_cur - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_calc) begin
      eff_mem[ch] <= eff_nx;
    end
  end
`else
  assign vol_idx = vol;
`endif

  // Flipping the MSB turns the 0..63 waveform into a signed -32..31 value.
  assign sig      = wave_val ^ 6'h20;
  assign prod     = $signed({{6{sig[5]}}, sig}) * $signed({6'd0, GAIN[vol_idx]});
  assign prod_ext = {{(ACC_W-12){prod[11]}}, prod};

  always_ff @(posedge clk) begin
    if (do_calc) begin
      phase_mem[ch] <= phase_new;
      noise_mem[ch] <= noise_new;
    end
  end

  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] a);
    // In range when every bit above the output sign bit matches the sign.
    if (a[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){a[ACC_W-1]}}) begin
      return a[OUT_W-1:0];
    end
    return a[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attr_word    <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      left_audio   <= '0;
      right_audio  <= '0;
      sample_valid <= 1'b0;
      lfsr         <= 16'd1;
      noise_sr     <= '0;
    end else begin
      lfsr     <= {lfsr[14:0], lfsr[1] ^ lfsr[2] ^ lfsr[4] ^ lfsr[15]};
      noise_sr <= {noise_sr[4:0], lfsr[0]};

      if (shift_en) begin
        attr_word <= {rd_data, attr_word[31:8]};
      end

      if (clr_acc) begin
        acc_l <= '0;
        acc_r <= '0;
      end else if (do_calc) begin
        if (left_en) begin
          acc_l <= acc_l + prod_ext;
        end
        if (right_en) begin
          acc_r <= acc_r + prod_ext;
        end
      end

      sample_valid <= load_out;
      if (load_out) begin
        left_audio  <= sat(acc_l);
        right_audio <= sat(acc_r);
      end
    end
  end

endmodule

// File: tb/tb_psg_multi.sv
// tb/tb_psg_multi.sv - directed scoreboard bench for psg_multi (32 voices, 16-bit output)

module tb_psg_multi;

  localparam int NUM_CH = 32;
  localparam int OUT_W  = 16;
  localparam int CH_W   = 5;
  localparam int AW     = CH_W + 2;
  localparam int LAT    = 6 * NUM_CH + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    attr_addr;
  logic [7:0]       attr_wrdata;
  logic             attr_write;
  logic             next_sample;
  logic [OUT_W-1:0] left_audio;
  logic [OUT_W-1:0] right_audio;
  logic             sample_valid;
  logic             overrun;

  always #5 clk = ~clk;

  psg_multi #(.NUM_CH(NUM_CH), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst(rst),
    .attr_addr(attr_addr),
    .attr_wrdata(attr_wrdata),
    .attr_write(attr_write),
    .next_sample(next_sample),
    .left_audio(left_audio),
    .right_audio(right_audio),
    .sample_valid(sample_valid),
    .overrun(overrun)
  );

  int    checks = 0;
  int    errors = 0;
  int    valid_cnt = 0;

  // Scoreboard: parallel queues pushed at stimulus time, popped on sample_valid.
  string q_tag [$];
  int    q_l [$];
  int    q_r [$];
  bit    q_chk [$];

  string m_tag;
  int    m_l, m_r;
  bit    m_chk;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sample_valid) begin
      valid_cnt++;
      chk("sb_pending", int'(q_tag.size() > 0), 1);
      if (q_tag.size() > 0) begin
        m_tag = q_tag.pop_front();
        m_l   = q_l.pop_front();
        m_r   = q_r.pop_front();
        m_chk = q_chk.pop_front();
        if (m_chk) begin
          chk($sformatf("%s_L", m_tag), $signed(left_audio), m_l);
          chk($sformatf("%s_R", m_tag), $signed(right_audio), m_r);
        end
      end
    end
  end

  task automatic wr_word(input int c, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      attr_addr   = AW'(c * 4 + b);
      attr_wrdata = w[8*b +: 8];
      attr_write  = 1'b1;
    end
    @(negedge clk);
    attr_write = 1'b0;
  endtask

  task automatic wr_all(input logic [31:0] w);
    for (int c = 0; c < NUM_CH; c++) begin
      wr_word(c, w);
    end
  endtask

  task automatic run_sample(input bit en, input int l, input int r, input string tag);
    int n;
    q_tag.push_back(tag);
    q_l.push_back(l);
    q_r.push_back(r);
    q_chk.push_back(en);
    @(negedge clk);
    next_sample = 1'b1;
    #1;
    if (en) chk({tag, "_ovr_idle"}, overrun, 0);
    @(negedge clk);
    next_sample = 1'b0;
    n = 1;
    while (!sample_valid && n < LAT + 20) begin
      @(negedge clk);
      n++;
    end
    if (en) chk({tag, "_latency"}, n, LAT);
    if (!sample_valid) begin
      void'(q_tag.pop_back());
      void'(q_l.pop_back());
      void'(q_r.pop_back());
      void'(q_chk.pop_back());
    end
    @(negedge clk);
    if (en) chk({tag, "_valid_pulse"}, sample_valid, 0);
  endtask

  task automatic settle();
`ifdef PSG_VOL_SLEW_EN
    repeat (64) run_sample(1'b0, 0, 0, "settle");
`endif
  endtask

  function automatic int saw_exp(input int k);
    int s;
    s = (k % 64) ^ 32;
    if (s >= 32) s -= 64;
    return s * 63;
  endfunction

  initial begin
    int n, v0, eff;
    int gain_lo [11] = '{0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2};

    rst         = 1'b1;
    attr_addr   = '0;
    attr_wrdata = '0;
    attr_write  = 1'b0;
    next_sample = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_left", left_audio, 0);
    chk("rst_right", right_audio, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", sample_valid, 0);

    wr_all(32'h0000_0000);

    // Pulse high on ch0, left only, full volume
    wr_word(0, 32'h3F7F_0000);
    settle();
    run_sample(1'b1, 1953, 0, "pulse");

    // Reset in the middle of a sample
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_left", left_audio, 0);
    chk("abort_right", right_audio, 0);
    chk("abort_valid", sample_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt;
    repeat (LAT + 20) @(negedge clk);
    chk("abort_no_valid", valid_cnt, v0);
    run_sample(1'b1, 1953, 0, "post_abort");

    // Saw sweep with wrap after 64 samples
    wr_word(0, 32'h407F_0800);
    for (int k = 0; k < 66; k++) begin
      run_sample(1'b1, saw_exp(k), 0, $sformatf("saw%0d", k));
    end

    // ch0 phase now 0x1000 (phase[16:10] = 4): pulse comparator boundary
    wr_word(0, 32'h037F_0000);
    run_sample(1'b1, -2016, 0, "pw_below");
    wr_word(0, 32'h047F_0000);
    run_sample(1'b1, 1953, 0, "pw_equal");

    // Two-voice mix: ch0 right only full volume, ch1 both sides volume 10
    wr_word(0, 32'h3FBF_0000);
    wr_word(1, 32'h3FCA_0000);
    settle();
    run_sample(1'b1, 62, 2015, "mix");

    // Saturation both directions
    wr_all(32'h3FFF_0000);
    settle();
    run_sample(1'b1, 32767, 32767, "sat_high");
    wr_all(32'h40FF_0000);
    run_sample(1'b1, -32768, -32768, "sat_low");

    // Overrun: second strobe 10 cycles after the first
    v0 = valid_cnt;
    q_tag.push_back("overrun_sample");
    q_l.push_back(-32768);
    q_r.push_back(-32768);
    q_chk.push_back(1'b1);
    @(negedge clk);
    next_sample = 1'b1;
    #1;
    chk("ovr_first", overrun, 0);
    @(negedge clk);
    next_sample = 1'b0;
    n = 1;
    repeat (9) begin
      @(negedge clk);
      n++;
    end
    next_sample = 1'b1;
    #1;
    chk("ovr_pulse", overrun, 1);
    @(negedge clk);
    next_sample = 1'b0;
    n++;
    #1;
    chk("ovr_one_cycle", overrun, 0);
    while (!sample_valid && n < LAT + 20) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_latency", n, LAT);
    repeat (LAT + 20) @(negedge clk);
    chk("ovr_single_valid", valid_cnt, v0 + 1);

    // Volume change 0 -> 10 on a pulse-high voice
    wr_all(32'h0000_0000);
    wr_word(0, 32'h3F40_0000);
    settle();
    wr_word(0, 32'h3F4A_0000);
`ifdef PSG_VOL_SLEW_EN
    eff = 0;
`else
    eff = 10;
`endif
    for (int k = 0; k < 12; k++) begin
      run_sample(1'b1, 31 * gain_lo[eff], 0, $sformatf("slew%0d", k));
      if (eff < 10) eff++;
    end

    chk("sb_drained", q_tag.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
